// File: rtl/mesh_config_sequencer_if.sv
// Host / mesh signal bundle for mesh_config_sequencer.
// slave: sequencer side. master: host and mesh side (drives commands and row_done).
interface mesh_config_sequencer_if #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned CFG_W = 64
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [ROWS*COLS*CFG_W-1:0]   cmd_words;
    logic                         cmd_systolic;
    logic [ROWS*CFG_W-1:0]        cfg_word;
    logic                         cfg_valid;
    logic                         mesh_load;
    logic                         mesh_systolic;
    logic                         mesh_run;
    logic [ROWS-1:0]              row_done;
    logic                         busy;
    logic                         done;
    logic                         err;

    modport slave (
        input  cmd_valid, cmd_words, cmd_systolic, row_done,
        output cmd_ready, cfg_word, cfg_valid, mesh_load, mesh_systolic, mesh_run,
               busy, done, err
    );

    modport master (
        output cmd_valid, cmd_words, cmd_systolic, row_done,
        input  cmd_ready, cfg_word, cfg_valid, mesh_load, mesh_systolic, mesh_run,
               busy, done, err
    );
endinterface

// File: rtl/mesh_config_sequencer.sv
// Configuration sequencer for the switch mesh: accepts one command, streams the
// per-row words column by column, lets them settle, then runs the mesh until every
// row reports done. Optional run-phase watchdog enabled by defining SEQ_TIMEOUT_EN.
module mesh_config_sequencer #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 4,
    parameter int unsigned CFG_W   = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic                    clk,
    input logic                    reset,
    mesh_config_sequencer_if.slave bus
);

    localparam int unsigned PTR_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(COLS - 1);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be nonzero");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StSettle = 3'd2,
        StRun    = 3'd3,
        StDone   = 3'd4
    } state_t;

    state_t                               state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][CFG_W-1:0] words_q, words_d;
    logic                                 sys_q, sys_d;
    logic [PTR_W-1:0]                     ptr_q, ptr_d;
    logic [PTR_W-1:0]                     cnt_q, cnt_d;
    logic [ROWS-1:0]                      mask_q, mask_d;
    logic                                 accept;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
`endif

    // Inputs are sampled only while idle; a command offered while busy is ignored.
    assign accept = bus.cmd_valid && (state_q == StIdle);

    // Main state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            words_q <= '0;
            sys_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            sys_q   <= sys_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`endif

    // Next-state logic: LOAD -> SETTLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        words_d = words_q;
        sys_d   = sys_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
`ifdef SEQ_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    words_d = bus.cmd_words;
                    sys_d   = bus.cmd_systolic;
                    ptr_d   = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (ptr_q == PTR_LAST) begin
                    ptr_d   = '0;
                    cnt_d   = PTR_LAST;
                    state_d = StSettle;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    mask_d  = '0;
`ifdef SEQ_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRun: begin
                mask_d = mask_q | bus.row_done;
                // Completion is checked first so it wins over a same-cycle timeout.
                if (&mask_d) begin
                    state_d = StDone;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Per-row beat selection; rows are zero outside LOAD.
    logic [ROWS-1:0][CFG_W-1:0] cfg_row;
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign cfg_row[r] = (state_q == StLoad) ? words_q[r][ptr_q] : '0;
    end

    // Outputs decode from registered state, so reset clears them immediately.
    always_comb begin
        bus.cmd_ready     = (state_q == StIdle);
        bus.busy          = (state_q != StIdle);
        bus.cfg_word      = cfg_row;
        bus.cfg_valid     = (state_q == StLoad);
        bus.mesh_load     = (state_q == StLoad) || (state_q == StSettle);
        bus.mesh_run      = (state_q == StRun);
        bus.done          = (state_q == StDone);
        bus.mesh_systolic = sys_q && (state_q != StIdle);
    end

`ifdef SEQ_TIMEOUT_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mesh_config_sequencer.sv
// Directed bench for mesh_config_sequencer with a queue of expected LOAD beats.
// Define SEQ_TIMEOUT_EN to exercise the watchdog (TIMEOUT=8 in that build).
module tb_mesh_config_sequencer;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned CFG_W = 64;
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 8;
`else
    localparam int unsigned TIMEOUT = 1024;
`endif
    localparam int unsigned WW = ROWS * COLS * CFG_W;
    localparam int unsigned RW = ROWS * CFG_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mesh_config_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .CFG_W(CFG_W)) bus ();

    mesh_config_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .CFG_W(CFG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] pattern_words();
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w[(r*COLS+c)*CFG_W +: CFG_W] = CFG_W'(r * 16 + c);
        return w;
    endfunction

    function automatic logic [WW-1:0] random_words();
        logic [WW-1:0] w;
        for (int i = 0; i < ROWS * COLS; i++)
            w[i*CFG_W +: CFG_W] = {$urandom(), $urandom()};
        return w;
    endfunction

    // Expected beat for column c: row r carries word [r][c].
    task automatic push_beats(input logic [WW-1:0] w);
        logic [RW-1:0] beat;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++)
                beat[r*CFG_W +: CFG_W] = w[(r*COLS+c)*CFG_W +: CFG_W];
            exp_q.push_back(beat);
        end
    endtask

    // Offer a command in an idle cycle; returns one cycle after acceptance.
    task automatic offer(input string tag, input logic [WW-1:0] w, input logic sys);
        bus.cmd_valid    = 1'b1;
        bus.cmd_words    = w;
        bus.cmd_systolic = sys;
        check({tag, "_ready_at_accept"}, RW'(bus.cmd_ready), RW'(1));
        push_beats(w);
        tick();
    endtask

    // Called at T+1; checks LOAD and SETTLE, returns at T+2*COLS+1 (first RUN cycle).
    task automatic check_load_settle(input string tag, input logic sys);
        logic [RW-1:0] beat;
        for (int c = 0; c < COLS; c++) begin
            if (c > 0) tick();
            check({tag, "_load_valid"}, RW'(bus.cfg_valid), RW'(1));
            check({tag, "_load_mesh_load"}, RW'(bus.mesh_load), RW'(1));
            check({tag, "_load_ready"}, RW'(bus.cmd_ready), RW'(0));
            check({tag, "_load_systolic"}, RW'(bus.mesh_systolic), RW'(sys));
            check({tag, "_sb_depth"}, RW'(exp_q.size()), RW'(COLS - c));
            if (exp_q.size() > 0) begin
                beat = exp_q.pop_front();
                check({tag, "_load_word"}, bus.cfg_word, beat);
            end
        end
        for (int s = 0; s < COLS; s++) begin
            tick();
            check({tag, "_settle_valid"}, RW'(bus.cfg_valid), RW'(0));
            check({tag, "_settle_word"}, bus.cfg_word, RW'(0));
            check({tag, "_settle_load"}, RW'(bus.mesh_load), RW'(1));
            check({tag, "_settle_run"}, RW'(bus.mesh_run), RW'(0));
        end
        tick();
        check({tag, "_run_rise"}, RW'(bus.mesh_run), RW'(1));
        check({tag, "_run_load"}, RW'(bus.mesh_load), RW'(0));
        check({tag, "_run_systolic"}, RW'(bus.mesh_systolic), RW'(sys));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, RW'(bus.cmd_ready), RW'(1));
        check({tag, "_busy"}, RW'(bus.busy), RW'(0));
        check({tag, "_cfg_valid"}, RW'(bus.cfg_valid), RW'(0));
        check({tag, "_cfg_word"}, bus.cfg_word, RW'(0));
        check({tag, "_mesh_load"}, RW'(bus.mesh_load), RW'(0));
        check({tag, "_mesh_run"}, RW'(bus.mesh_run), RW'(0));
        check({tag, "_systolic"}, RW'(bus.mesh_systolic), RW'(0));
        check({tag, "_done"}, RW'(bus.done), RW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: observed no summary, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [WW-1:0] wa, wb;
        bus.cmd_valid    = 1'b0;
        bus.cmd_words    = '0;
        bus.cmd_systolic = 1'b0;
        bus.row_done     = '0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        check_idle("reset");
        check("reset_err", RW'(bus.err), RW'(0));
        tick();
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Command 1: word[r][c] = r*16+c, systolic, row_done pulses
        offer("t1", pattern_words(), 1'b1);
        bus.cmd_valid = 1'b0;
        check_load_settle("t1", 1'b1);                        // now T+9
        tick(); bus.row_done = 4'b0101;                       // T+10
        check("t1_done_early", RW'(bus.done), RW'(0));
        tick(); bus.row_done = 4'b0000;                       // T+11
        tick(); bus.row_done = 4'b1000;                       // T+12
        tick(); bus.row_done = 4'b0000;                       // T+13
        tick();                                               // T+14
        tick(); bus.row_done = 4'b0010;                       // T+15
        check("t1_done_t15", RW'(bus.done), RW'(0));
        check("t1_run_t15", RW'(bus.mesh_run), RW'(1));
        tick(); bus.row_done = 4'b0000;                       // T+16
        check("t1_done_pulse", RW'(bus.done), RW'(1));
        check("t1_done_run", RW'(bus.mesh_run), RW'(0));
        check("t1_done_busy", RW'(bus.busy), RW'(1));
        check("t1_done_ready", RW'(bus.cmd_ready), RW'(0));
        tick();                                               // T+17
        check_idle("t1_after");

        // Command 2 with level row_done; cmd_valid held with new data throughout
        wa = random_words();
        wb = random_words();
        wb[0] = ~wa[0];
        offer("t2", wa, 1'b0);
        bus.cmd_words    = wb;
        bus.cmd_systolic = 1'b1;
        check_load_settle("t2", 1'b0);                        // T+9
        bus.row_done = 4'b1111;
        push_beats(wb);
        tick();                                               // T+10
        check("t2_done_pulse", RW'(bus.done), RW'(1));
        check("t2_no_accept_in_done", RW'(bus.cmd_ready), RW'(0));
        tick();                                               // T+11 idle, accepts wb
        check("t2_idle_ready", RW'(bus.cmd_ready), RW'(1));
        check("t2_idle_cfg_valid", RW'(bus.cfg_valid), RW'(0));
        check("t2_idle_done", RW'(bus.done), RW'(0));
        check("t2_idle_systolic", RW'(bus.mesh_systolic), RW'(0));
        tick();
        bus.cmd_valid = 1'b0;
        check_load_settle("t3", 1'b1);
        tick();
        check("t3_done_pulse", RW'(bus.done), RW'(1));
        tick();
        bus.row_done = '0;
        check_idle("t3_after");

        // Reset during LOAD, then restart from column 0
        offer("t4", random_words(), 1'b1);
        bus.cmd_valid = 1'b0;
        check("t4_load", RW'(bus.cfg_valid), RW'(1));         // T+1
        tick();
        tick();                                               // T+3
        reset = 1'b1;
        #1;
        check_idle("t4_async_reset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t4_no_done", RW'(bus.done), RW'(0));
        check("t4_ready", RW'(bus.cmd_ready), RW'(1));
        offer("t5", random_words(), 1'b0);
        bus.cmd_valid = 1'b0;
        check_load_settle("t5", 1'b0);
        bus.row_done = 4'b1111;
        tick();
        check("t5_done_pulse", RW'(bus.done), RW'(1));
        tick();
        bus.row_done = '0;
        check_idle("t5_after");

`ifdef SEQ_TIMEOUT_EN
        // Watchdog expires after TIMEOUT RUN cycles with an incomplete mask
        offer("t6", random_words(), 1'b1);
        bus.cmd_valid = 1'b0;
        check_load_settle("t6", 1'b1);                        // RUN cycle 1
        bus.row_done = 4'b0111;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check("t6_run_hold", RW'(bus.mesh_run), RW'(1));
            check("t6_no_done", RW'(bus.done), RW'(0));
            check("t6_no_err_yet", RW'(bus.err), RW'(0));
        end
        tick();
        check("t6_err", RW'(bus.err), RW'(1));
        check("t6_timeout_done", RW'(bus.done), RW'(0));
        check("t6_timeout_run", RW'(bus.mesh_run), RW'(0));
        check("t6_timeout_ready", RW'(bus.cmd_ready), RW'(1));
        tick();
        check("t6_err_sticky", RW'(bus.err), RW'(1));
        bus.row_done = '0;

        // Next command clears err; completion on the last watchdog cycle wins
        offer("t7", random_words(), 1'b0);
        bus.cmd_valid = 1'b0;
        check("t7_err_cleared", RW'(bus.err), RW'(0));
        check_load_settle("t7", 1'b0);
        bus.row_done = 4'b0111;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check("t7_no_done", RW'(bus.done), RW'(0));
            if (i == TIMEOUT - 1) bus.row_done = 4'b1111;
        end
        tick();
        check("t7_done_wins", RW'(bus.done), RW'(1));
        check("t7_err_low", RW'(bus.err), RW'(0));
        tick();
        bus.row_done = '0;
        check_idle("t7_after");
`else
        // Without the watchdog RUN waits indefinitely and err stays low
        offer("t6", random_words(), 1'b1);
        bus.cmd_valid = 1'b0;
        check_load_settle("t6", 1'b1);
        bus.row_done = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t6_run_hold", RW'(bus.mesh_run), RW'(1));
            check("t6_no_done", RW'(bus.done), RW'(0));
            check("t6_err_low", RW'(bus.err), RW'(0));
        end
        bus.row_done = 4'b1111;
        tick();
        check("t6_done_pulse", RW'(bus.done), RW'(1));
        tick();
        bus.row_done = '0;
        check_idle("t6_after");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mesh_config_sequencer.md
Name: mesh_config_sequencer

Overview:
- Controller in front of the 4x4 switch mesh. Accepts one configuration command: per-row map instruction words plus a systolic mode flag.
- Streams the words column-by-column into the mesh row configuration ports, waits for them to settle through the switch chain, then runs the mesh until every row reports done.
- Provides a single valid/ready command interface to the host, so the mesh is never reconfigured while it is running.

Parameters:
- ROWS, 4, number of mesh rows (one configuration port per row)
- COLS, 4, number of switch columns; also the number of configuration beats per row
- CFG_W, 64, configuration word width
- TIMEOUT, 1024, run-phase watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_words  in  ROWS*COLS*CFG_W  word [r][c] at bit offset (r*COLS+c)*CFG_W
- cmd_systolic  in  1  systolic mode for this command
- cfg_word  out  ROWS*CFG_W  per-row configuration word; row r at bit offset r*CFG_W
- cfg_valid  out  1  cfg_word holds a valid beat this cycle
- mesh_load  out  1  load strobe to the mesh; high during LOAD and SETTLE
- mesh_systolic  out  1  latched systolic flag; held for the whole command
- mesh_run  out  1  mesh execution enable
- row_done  in  ROWS  per-row completion; may be a pulse or a level
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the command completes
- err  out  1  sticky timeout flag; cleared when the next command is accepted

Behaviour:
- Reset (asynchronous): state=IDLE, every output 0 except cmd_ready=1. Internal registers cleared: column pointer, settle counter, done mask, watchdog.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid && cmd_ready.
  - The cycle it is accepted: cmd_words and cmd_systolic are latched, the column pointer is set to 0, and the FSM goes to LOAD.
  - cmd_valid while busy is ignored; the inputs are not sampled.
- LOAD, COLS cycles.
  - cfg_valid=1, mesh_load=1.
  - cfg_word row r = latched word [r][ptr].
  - ptr increments each cycle. After the beat with ptr==COLS-1, go to SETTLE with ptr=0.
- SETTLE, COLS cycles: cfg_valid=0, cfg_word=0, mesh_load=1, counter counts COLS-1 down to 0. At 0, go to RUN and clear the done mask.
- RUN:
  - mesh_run=1, mesh_load=0.
  - Each cycle: done mask |= row_done.
  - When the mask becomes all ones, go to DONE. This includes the case where all bits are set in one cycle, and bits arriving on the first RUN cycle.
  - row_done is ignored outside RUN.
- DONE, 1 cycle: done=1, mesh_run=0, then IDLE. mesh_systolic returns to 0 in IDLE.
- Timing, with acceptance at cycle T (registered outputs):
  - LOAD beats at T+1..T+COLS.
  - SETTLE at T+COLS+1..T+2*COLS.
  - mesh_run first high at T+2*COLS+1.
  - done is high the cycle after the last done-mask bit is captured.
- Back-to-back commands: cmd_ready is high again in the cycle after DONE. There is no same-cycle accept in DONE.
- Reset asserted mid-operation: immediate return to IDLE. Outputs drop in the same cycle as reset (asynchronous); no done pulse is produced.
- State encoding: IDLE, LOAD, SETTLE, RUN, DONE. Unused encodings go to IDLE.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT without a full done mask: err=1, mesh_run=0, and the FSM goes to IDLE without a done pulse.
  - If the mask completes on the same cycle the watchdog reaches TIMEOUT, completion wins: done pulse, err stays 0.
- SEQ_TIMEOUT_EN not defined: no watchdog logic, err tied 0, RUN waits indefinitely.

Test Plan:
- Reset, then send one command with word[r][c]=r*16+c and cmd_systolic=1. Accept at T -> at T+1..T+4 cfg_word rows = {0x00,0x10,0x20,0x30}, {0x01,...}, ... {0x03,0x13,0x23,0x33}; mesh_systolic=1; mesh_run rises at T+9.
- In RUN, pulse row_done bits 0,2 at T+10, bit 3 at T+12, bit 1 at T+15 -> done pulse at T+16, cmd_ready=1 at T+17, mesh_systolic=0.
- row_done=4'b1111 held as a level from T+9 -> done at T+10.
- Hold cmd_valid high with different data throughout the first command -> second command accepted only at the IDLE cycle after DONE, with its own data latched.
- Assert reset at T+3 during LOAD -> all outputs 0 at once, cmd_ready=1; a new command after reset is sequenced from column 0.
- With SEQ_TIMEOUT_EN and TIMEOUT=8, row_done held at 4'b0111 -> err=1 and return to IDLE after 8 RUN cycles, no done pulse; the next accepted command clears err.
